// File: rtl/stereo_audio_parallelizer_if.sv
// Handshake bundle for the stereo parallelizer: tagged serial words in, left/right pairs out.
// slave = the parallelizer itself, master = the surrounding producer/consumer.
interface stereo_audio_parallelizer_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             i_ready;
  logic             i_is_left;
  logic [WIDTH-1:0] i_audio;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_left;
  logic [WIDTH-1:0] o_right;

  modport slave (
    input  i_valid, i_is_left, i_audio, o_ready,
    output i_ready, o_valid, o_left, o_right
  );

  modport master (
    output i_valid, i_is_left, i_audio, o_ready,
    input  i_ready, o_valid, o_left, o_right
  );
endinterface

// File: rtl/stereo_audio_parallelizer.sv
// Pairs interleaved left/right audio words into one parallel stereo frame per right word.
// Optional macro STEREO_AUDIO_PARALLELIZER_RESYNC_EN: drop right words that arrive without a held left word.
module stereo_audio_parallelizer #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  stereo_audio_parallelizer_if.slave  bus
);

  logic [WIDTH-1:0] left_reg;
  logic [WIDTH-1:0] o_left_reg;
  logic [WIDTH-1:0] o_right_reg;
  logic             o_valid_reg;
  logic             in_fire;
  logic             out_fire;
  logic             pair_ok;

  // Input is stalled for the whole time a pair is pending, so in_fire and out_fire never coincide.
  assign in_fire  = bus.i_valid && !o_valid_reg;
  assign out_fire = o_valid_reg && bus.o_ready;

`ifdef STEREO_AUDIO_PARALLELIZER_RESYNC_EN
  logic have_left_reg;

  assign pair_ok = have_left_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      have_left_reg <= 1'b0;
    end else if (in_fire) begin
      have_left_reg <= bus.i_is_left;
    end
  end
`else
  assign pair_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_reg    <= '0;
      o_left_reg  <= '0;
      o_right_reg <= '0;
      o_valid_reg <= 1'b0;
    end else begin
      if (out_fire) begin
        o_valid_reg <= 1'b0;
      end
      if (in_fire) begin
        if (bus.i_is_left) begin
          left_reg <= bus.i_audio;
        end else if (pair_ok) begin
          o_left_reg  <= left_reg;
          o_right_reg <= bus.i_audio;
          o_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.i_ready = !o_valid_reg;
  assign bus.o_valid = o_valid_reg;
  assign bus.o_left  = o_left_reg;
  assign bus.o_right = o_right_reg;

endmodule

// File: tb/tb_stereo_audio_parallelizer.sv
// Directed bench for stereo_audio_parallelizer; expectations follow the build's resync macro.
module tb_stereo_audio_parallelizer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  stereo_audio_parallelizer_if #(.WIDTH(32)) bus ();

  stereo_audio_parallelizer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word and return #1 after the edge that accepted it.
  task automatic send(input logic is_left, input logic [31:0] data);
    int wait_cycles = 0;
    bus.i_valid   = 1'b1;
    bus.i_is_left = is_left;
    bus.i_audio   = data;
    while (bus.i_ready !== 1'b1 && wait_cycles < 50) begin
      tick();
      wait_cycles++;
    end
    if (wait_cycles >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed i_ready stuck low expected 1 within 50 cycles");
    end
    tick();
    bus.i_valid = 1'b0;
  endtask

  // Pair must be visible now; hold it for 'hold' cycles, then consume it once.
  task automatic consume(input string tag, input logic [31:0] l, input logic [31:0] r, input int hold);
    check({tag, "_valid"}, {31'd0, bus.o_valid}, 32'd1);
    check({tag, "_left"},  bus.o_left,  l);
    check({tag, "_right"}, bus.o_right, r);
    check({tag, "_iready_low"}, {31'd0, bus.i_ready}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, {31'd0, bus.o_valid}, 32'd1);
      check({tag, "_hold_left"},  bus.o_left,  l);
      check({tag, "_hold_right"}, bus.o_right, r);
      check({tag, "_hold_iready"}, {31'd0, bus.i_ready}, 32'd0);
    end
    bus.o_ready = 1'b1;
    tick();
    bus.o_ready = 1'b0;
    check({tag, "_consumed_valid"}, {31'd0, bus.o_valid}, 32'd0);
    check({tag, "_consumed_iready"}, {31'd0, bus.i_ready}, 32'd1);
    $display("pair %s: l=%h r=%h", tag, l, r);
  endtask

  task automatic expect_none(input string tag);
    check({tag, "_no_valid"}, {31'd0, bus.o_valid}, 32'd0);
    tick();
    check({tag, "_no_valid_next"}, {31'd0, bus.o_valid}, 32'd0);
    $display("no pair %s", tag);
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  logic [31:0] frames_l [5];
  logic [31:0] frames_r [5];

  initial begin
    frames_l = '{32'h00010000, 32'h2eef2eef, 32'h12345678, 32'h99911223, 32'h55555555};
    frames_r = '{32'h1fed1fed, 32'h33333333, 32'h1fed1fed, 32'habcdef01, 32'h44444444};
    reset         = 1'b1;
    bus.i_valid   = 1'b0;
    bus.i_is_left = 1'b0;
    bus.i_audio   = '0;
    bus.o_ready   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("reset_o_left",  bus.o_left,  32'd0);
    check("reset_o_right", bus.o_right, 32'd0);
    check("reset_i_ready", {31'd0, bus.i_ready}, 32'd1);

    // Single frame with an always-ready consumer: o_valid lasts exactly one cycle.
    bus.o_ready = 1'b1;
    send(1'b1, 32'h00010000);
    check("t1_no_early_valid", {31'd0, bus.o_valid}, 32'd0);
    send(1'b0, 32'h1fed1fed);
    check("t1_valid",  {31'd0, bus.o_valid}, 32'd1);
    check("t1_left",   bus.o_left,  32'h00010000);
    check("t1_right",  bus.o_right, 32'h1fed1fed);
    tick();
    check("t1_valid_one_cycle", {31'd0, bus.o_valid}, 32'd0);
    check("t1_iready_back", {31'd0, bus.i_ready}, 32'd1);
    bus.o_ready = 1'b0;
    $display("pair t1: l=00010000 r=1fed1fed");

    // Five frames, consumer stalls 4 cycles after each pair.
    for (int f = 0; f < 5; f++) begin
      send(1'b1, frames_l[f]);
      send(1'b0, frames_r[f]);
      consume($sformatf("frame%0d", f), frames_l[f], frames_r[f], 4);
    end

    // Long stall: pair and i_ready must hold until o_ready rises.
    send(1'b1, 32'hcafef00d);
    send(1'b0, 32'h0badbeef);
    consume("long_hold", 32'hcafef00d, 32'h0badbeef, 10);

    // Second left word overwrites the first.
    send(1'b1, 32'h11111111);
    send(1'b1, 32'h22222222);
    check("dbl_left_no_valid", {31'd0, bus.o_valid}, 32'd0);
    send(1'b0, 32'h33333333);
    consume("dbl_left", 32'h22222222, 32'h33333333, 1);

    // Right word straight after reset.
    do_reset();
    send(1'b0, 32'haaaaaaaa);
`ifdef STEREO_AUDIO_PARALLELIZER_RESYNC_EN
    expect_none("r_after_reset");
`else
    consume("r_after_reset", 32'h00000000, 32'haaaaaaaa, 1);
`endif

    // Reset mid-frame discards the held left word.
    send(1'b1, 32'h12345678);
    do_reset();
    check("midreset_o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("midreset_i_ready", {31'd0, bus.i_ready}, 32'd1);
    send(1'b0, 32'h87654321);
`ifdef STEREO_AUDIO_PARALLELIZER_RESYNC_EN
    expect_none("midreset");
`else
    consume("midreset", 32'h00000000, 32'h87654321, 1);
`endif

    // Normal framing resumes afterwards.
    send(1'b1, 32'hdeadbeef);
    send(1'b0, 32'h01234567);
    consume("after_reset_frame", 32'hdeadbeef, 32'h01234567, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stereo_audio_parallelizer.md
# stereo_audio_parallelizer

Converts a serial stream of interleaved stereo audio words, each tagged left or right, into one parallel left/right sample pair per stereo frame. It sits between a serial audio receiver (e.g. an I2S deserializer) and frame-oriented processing such as the echo/delay datapath. Both sides use valid/ready handshakes. One output pair is emitted for each left word followed by a right word.

## Interface
- WIDTH, 32, bit width of one audio word.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  input word present.
- i_ready  output  1  block can accept an input word; a transfer occurs when i_valid && i_ready at a rising clk edge.
- i_is_left  input  1  1 = word is the left channel, 0 = right channel; qualified by i_valid.
- i_audio  input  WIDTH  audio word.
- o_valid  output  1  output pair present.
- o_ready  input  1  consumer accepts the pair; a transfer occurs when o_valid && o_ready at a rising clk edge.
- o_left  output  WIDTH  left sample of the pair.
- o_right  output  WIDTH  right sample of the pair.

## Operation
- Internal state: left holding register (WIDTH), have_left flag, output registers o_left/o_right, o_valid flag.
- Reset values: o_valid=0, o_left=0, o_right=0, left register=0, have_left=0. i_ready=1 after reset, because i_ready = ~o_valid.
- i_ready = ~o_valid, combinational from the register; it does not depend on o_ready or i_valid.
- Left word accepted: left register <= i_audio; have_left <= 1. A second left word before a right word overwrites the first; no output is produced.
- Right word accepted, pairing allowed (see Configuration): o_left <= left register, o_right <= i_audio, o_valid <= 1, have_left <= 0.
- Output accepted (o_valid && o_ready): o_valid <= 0. o_left/o_right hold their last values.
- While o_valid=1 no input is accepted, so a pending pair is never overwritten. o_left/o_right are stable while o_valid=1.
- Data is passed bit-exact. No arithmetic and no sign handling.
- Reset asserted mid-frame discards a held left word and any pending pair.

## Timing
- Latency: o_valid rises on the clk edge that accepts the right word. The pair is visible in the following cycle.
- The earliest pair consumption is the next edge. i_ready returns to 1 in the cycle after the consuming edge, so the minimum rate is one pair per 2 cycles on the right-word path.
- Left words need no output slot, but they are still blocked while o_valid=1. This keeps the design simple and deterministic.
- Because i_ready depends only on registered state, there is no combinational path from o_ready to i_ready.
- When a right word is accepted while o_valid=0, there is no simultaneous input/output event to resolve.

## Configuration
- STEREO_AUDIO_PARALLELIZER_RESYNC_EN defined: a right word accepted while have_left=0 is consumed (i_ready handshake completes) but discarded, with no output. This resynchronizes framing to left-first after reset or a glitch.
- Not defined: every accepted right word produces a pair using the current left register contents. After reset that value is 0; otherwise it is the last left word.

## Test plan
- Reset, o_ready=1; send L=00010000, R=1fed1fed -> one pair l=00010000 r=1fed1fed; o_valid high for exactly one cycle.
- Send five L/R frames (00010000/1fed1fed, 2eef2eef/33333333, 12345678/1fed1fed, 99911223/abcdef01, 55555555/44444444). The consumer deasserts o_ready for 4 cycles after each pair. Expect 5 pairs in order with exact values; i_ready=0 whenever o_valid=1.
- Hold o_ready=0 after a pair is formed -> o_valid, o_left and o_right stay stable and i_ready stays 0. Raise o_ready -> pair consumed once, and i_ready=1 the next cycle.
- Send L=11111111, L=22222222, R=33333333 -> single pair l=22222222 r=33333333.
- Send R=aaaaaaaa immediately after reset -> with RESYNC_EN, no output; without it, pair l=00000000 r=aaaaaaaa.
- Assert reset after L=12345678 is accepted, then send R=87654321 -> RESYNC_EN: no output; otherwise l=00000000 r=87654321.
